// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its read-select tree.
package regfile_pkg;

   localparam int ZERO_NONE = -1;

   typedef logic [31:0] reg_idx_t;

   // Select width for an n-entry selector; never below one bit.
   function automatic int addr_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_np_mux.sv
// muxNx1: WIDTH-bit N-input selector built as a recursive 2:1 tree (N >= 2).
// A select past N-1 returns an arbitrary input; the caller masks that case.
module muxNx1
   import regfile_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int N = 2,
   localparam int SW = addr_width(N)
) (
   input  logic [N*WIDTH-1:0] din,
   input  logic [SW-1:0]      sel,
   output logic [WIDTH-1:0]   dout
);

   generate
      if (N == 2) begin : g_leaf
         assign dout = sel[0] ? din[2*WIDTH-1:WIDTH] : din[WIDTH-1:0];
      end else begin : g_split
         // Lower half is the largest power of two below N so the top select bit
         // cleanly chooses between the two subtrees.
         localparam int L  = 1 << (SW - 1);
         localparam int H  = N - L;
         localparam int HW = addr_width(H);

         logic [WIDTH-1:0] lo;
         logic [WIDTH-1:0] hi;

         muxNx1 #(
            .WIDTH(WIDTH),
            .N    (L)
         ) u_lo (
            .din (din[L*WIDTH-1:0]),
            .sel (sel[SW-2:0]),
            .dout(lo)
         );

         if (H == 1) begin : g_hi_single
            assign hi = din[N*WIDTH-1 -: WIDTH];
         end else begin : g_hi_tree
            muxNx1 #(
               .WIDTH(WIDTH),
               .N    (H)
            ) u_hi (
               .din (din[N*WIDTH-1:L*WIDTH]),
               .sel (sel[HW-1:0]),
               .dout(hi)
            );
         end

         assign dout = sel[SW-1] ? hi : lo;
      end
   endgenerate

endmodule

// File: rtl/regfile_np.sv
// regfile_np: DEPTH x WIDTH register file with NUM_READ independent read ports,
// optional hardwired zero register, write-to-read bypass and registered read.
module regfile_np
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = 31,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0,
   localparam int AW = addr_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [NUM_READ*AW-1:0]    rd_addr,
   output logic [NUM_READ*WIDTH-1:0] rd_data
);

   localparam bit ZERO_EN = (ZERO_REG != ZERO_NONE) && (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
   localparam bit PARTIAL = DEPTH < (1 << AW);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [DEPTH*WIDTH-1:0] mem_flat;
   logic                   wr_in_range;
   logic                   wr_not_zero;

   generate
      if (PARTIAL) begin : g_wr_range
         assign wr_in_range = wr_addr < AW'(DEPTH);
      end else begin : g_wr_full
         assign wr_in_range = 1'b1;
      end

      if (ZERO_EN) begin : g_wr_zero
         assign wr_not_zero = wr_addr != AW'(ZERO_REG);
      end else begin : g_wr_nozero
         assign wr_not_zero = 1'b1;
      end
   endgenerate

   // The zero entry is never written, so it holds its reset value of 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else if (wr_en && wr_in_range && wr_not_zero) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      mem_flat = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_flat[i*WIDTH +: WIDTH] = mem[AW'(i)];
      end
   end

   generate
      for (genvar p = 0; p < NUM_READ; p++) begin : g_port
         logic [AW-1:0]    addr;
         logic [WIDTH-1:0] tree;
         logic [WIDTH-1:0] val;
         logic             out_of_range;
         logic             is_zero;
         logic             hit;

         assign addr = rd_addr[p*AW +: AW];

         muxNx1 #(
            .WIDTH(WIDTH),
            .N    (DEPTH)
         ) u_mux (
            .din (mem_flat),
            .sel (addr),
            .dout(tree)
         );

         if (PARTIAL) begin : g_oor
            assign out_of_range = addr >= AW'(DEPTH);
         end else begin : g_no_oor
            assign out_of_range = 1'b0;
         end

         if (ZERO_EN) begin : g_zero
            assign is_zero = addr == AW'(ZERO_REG);
         end else begin : g_no_zero
            assign is_zero = 1'b0;
         end

         if (BYPASS != 0) begin : g_byp
            assign hit = wr_en && (wr_addr == addr);
         end else begin : g_no_byp
            assign hit = 1'b0;
         end

         // Zero/out-of-range override the bypass, which overrides storage.
         always_comb begin
            val = tree;
            if (hit) begin
               val = wr_data;
            end
            if (out_of_range || is_zero) begin
               val = '0;
            end
         end

         if (READ_REG != 0) begin : g_rdreg
            logic [WIDTH-1:0] q;

            always_ff @(posedge clk) begin
               if (reset) begin
                  q <= '0;
               end else begin
                  q <= val;
               end
            end

            assign rd_data[p*WIDTH +: WIDTH] = q;
         end else begin : g_rdcomb
            assign rd_data[p*WIDTH +: WIDTH] = val;
         end
      end
   endgenerate

endmodule
